stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Memory-stage stack and address controller for the 8-bit pipelined processor. It sits beside the memory-stage control decode, takes the same 8-bit instruction word, and drives the data-memory address and write enable. It owns the stack pointer (SP). It sequences the two-access operations, RTI and interrupt entry, by stalling the upstream pipeline for one extra cycle.

## Interface
Parameters:
- SP_RESET, 8'hFF, SP value after reset (empty stack).
- STACK_LIMIT, 8'h80, lowest legal push address; used only with the guard feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ir  in  8  memory-stage instruction: op=ir[7:4], ra=ir[3:2].
- valid  in  1  ir is a real instruction; 0 means a bubble.
- irq_take  in  1  interrupt entry request (level, held until irq_ack).
- alu_addr  in  8  EX-stage address for LDD/STD/LDI/STI.
- mem_addr  out  8  data-memory address.
- mem_we  out  1  data-memory write enable.
- flags_sel  out  1  current stack access carries flags, not PC/register data.
- stall  out  1  hold IF/ID/EX and this stage's input register.
- irq_ack  out  1  one-cycle pulse when interrupt entry completes.
- sp  out  8  current stack pointer.
- stk_err  out  1  sticky stack fault (guard build only).

## Operation
- Decode, valid=1, state IDLE:
  - push (op 7, ra 0) and call (op 11, ra 1): mem_addr=sp, mem_we=1, sp<=sp-1.
  - pop (op 7, ra 1) and ret (op 11, ra 2): mem_addr=sp+1, sp<=sp+1.
  - STD (op 12, ra 2) and STI (op 14): mem_addr=alu_addr, mem_we=1.
  - LDD (op 12, ra 1) and LDI (op 13): mem_addr=alu_addr.
  - All other codes: mem_addr=alu_addr, mem_we=0, sp unchanged.
- FSM states: IDLE, RTI2, INT1, INT2.
- RTI (op 11, ra 3) runs in two cycles:
  - IDLE cycle: pops flags. mem_addr=sp+1, flags_sel=1, sp<=sp+1, stall=1, next RTI2.
  - RTI2: pops PC. mem_addr=sp+1, sp<=sp+1, stall=0, next IDLE.
- Interrupt entry is honoured only when IDLE and valid=0. If valid=1, the instruction executes and irq_take waits.
  - IDLE with irq_take: next INT1, no memory access that cycle, stall=1.
  - INT1: pushes PC. mem_addr=sp, mem_we=1, sp<=sp-1, stall=1, next INT2.
  - INT2: pushes flags. mem_addr=sp, mem_we=1, flags_sel=1, sp<=sp-1, irq_ack=1, stall=0, next IDLE.
- In RTI2, INT1 and INT2, ir, valid and irq_take are ignored.
- Arithmetic: SP math is 8-bit modulo 256 unless the guard feature is compiled in.

## Timing
- mem_addr, mem_we, flags_sel, stall and irq_ack are combinational from state, ir, valid, sp and alu_addr.
- sp and state are registered; an SP change is visible the cycle after the access.
- Push then pop on back-to-back cycles returns the same address.
- RTI occupies 2 cycles with 1 stall cycle.
- Interrupt entry occupies 3 cycles (IDLE-detect, INT1, INT2); stall is high for the first 2.
- Reset (async, any state, including mid-RTI or mid-INT):
  - state=IDLE, sp=SP_RESET, stk_err=0.
  - While rst=1: mem_we=0, stall=0, irq_ack=0, flags_sel=0, mem_addr=alu_addr.

## Configuration
- Macro STACK_GUARD_EN defined:
  - Push-type access at sp==STACK_LIMIT, or pop-type access at sp==8'hFF, sets stk_err.
  - For that access: mem_we forced 0 and sp unchanged.
  - The FSM still advances normally.
  - stk_err is cleared only by rst.
- Macro not defined: SP wraps (8'h00-1 gives 8'hFF; 8'hFF+1 gives 8'h00), stk_err tied 0.

## Structure
- Shared package holds:
  - opcode constants: OP_STACK=7, OP_FLOW=11, OP_LDST=12, OP_LDI=13, OP_STI=14.
  - ra subcodes: PUSH, POP, CALL, RET, RTI, LDD, STD.
  - state enum: IDLE, RTI2, INT1, INT2.
- Sub-module stack_decode: combinational ir/valid to {push_t, pop_t, is_rti, mem_wr, use_alu}.
- The FSM and SP register stay in stack_ctrl.

## Test plan
- Reset, then push with ir=8'h70: mem_addr=8'hFF, mem_we=1; next cycle sp=8'hFE.
- Push, then pop with ir=8'h74: pop mem_addr=8'hFF, mem_we=0, sp returns to 8'hFF.
- With sp=8'hFD, RTI with ir=8'hBC:
  - cycle 1: mem_addr=8'hFE, flags_sel=1, stall=1.
  - cycle 2: mem_addr=8'hFF, flags_sel=0, stall=0.
  - then sp=8'hFF.
- irq_take=1 with valid=0 at sp=8'hFF:
  - INT1 writes 8'hFF.
  - INT2 writes 8'hFE with flags_sel=1 and irq_ack=1.
  - sp ends 8'hFD; stall is high for exactly 2 cycles.
- irq_take=1 with valid=1 and STD ir=8'hC8, alu_addr=8'h20: mem_addr=8'h20, mem_we=1, no INT1 that cycle.
- rst asserted in INT1: state IDLE and sp=SP_RESET immediately. Guard build: 129 pushes from 8'hFF sets stk_err and leaves sp=8'h80.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared opcode/subcode constants, FSM state type and decode bundle for stack_ctrl.
package stack_ctrl_pkg;

  localparam logic [3:0] OP_STACK = 4'd7;
  localparam logic [3:0] OP_FLOW  = 4'd11;
  localparam logic [3:0] OP_LDST  = 4'd12;
  localparam logic [3:0] OP_LDI   = 4'd13;
  localparam logic [3:0] OP_STI   = 4'd14;

  // ra subcodes; meaning depends on the opcode they accompany
  localparam logic [1:0] RA_PUSH = 2'd0;
  localparam logic [1:0] RA_POP  = 2'd1;
  localparam logic [1:0] RA_CALL = 2'd1;
  localparam logic [1:0] RA_RET  = 2'd2;
  localparam logic [1:0] RA_RTI  = 2'd3;
  localparam logic [1:0] RA_LDD  = 2'd1;
  localparam logic [1:0] RA_STD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RTI2 = 2'd1,
    INT1 = 2'd2,
    INT2 = 2'd3
  } state_t;

  typedef struct packed {
    logic push_t;
    logic pop_t;
    logic is_rti;
    logic mem_wr;
    logic use_alu;
  } stack_dec_t;

endpackage

// File: rtl/stack_ctrl_decode.sv
// Combinational memory-stage decode of ir/valid into stack and load/store classes.
module stack_decode
  import stack_ctrl_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       valid,
  output stack_dec_t dec
);

  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] ir_unused;

  assign op        = ir[7:4];
  assign ra        = ir[3:2];
  assign ir_unused = ir[1:0];

  always_comb begin
    dec = '0;
    if (valid) begin
      dec.push_t = ((op == OP_STACK) && (ra == RA_PUSH)) ||
                   ((op == OP_FLOW)  && (ra == RA_CALL));
      dec.pop_t  = ((op == OP_STACK) && (ra == RA_POP)) ||
                   ((op == OP_FLOW)  && (ra == RA_RET));
      dec.is_rti = (op == OP_FLOW) && (ra == RA_RTI);
      dec.mem_wr = ((op == OP_LDST) && (ra == RA_STD)) || (op == OP_STI);
      // LDD/LDI and every unlisted code simply present alu_addr with no write
      dec.use_alu = !(dec.push_t || dec.pop_t || dec.is_rti);
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Memory-stage stack pointer, data-memory address and RTI/interrupt-entry sequencer.
// Optional build macro STACK_GUARD_EN adds overflow/underflow protection with sticky stk_err.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       valid,
  input  logic       irq_take,
  input  logic [7:0] alu_addr,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic       flags_sel,
  output logic       stall,
  output logic       irq_ack,
  output logic [7:0] sp,
  output logic       stk_err,
  output state_t     state_dbg
);

  // Handshake: stall=1 means upstream must hold IF/ID/EX and this stage's input
  // register; the instruction presented with stall=1 is consumed and must not be re-issued.

  state_t     state, next_state;
  stack_dec_t dec;
  logic [7:0] sp_next;
  logic [7:0] addr_raw;
  logic       we_raw, flags_raw, stall_raw, ack_raw;
  logic       push_acc, pop_acc, fault;

  stack_decode u_decode (
    .ir    (ir),
    .valid (valid),
    .dec   (dec)
  );

  always_comb begin
    next_state = state;
    addr_raw   = alu_addr;
    we_raw     = 1'b0;
    flags_raw  = 1'b0;
    stall_raw  = 1'b0;
    ack_raw    = 1'b0;
    push_acc   = 1'b0;
    pop_acc    = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (dec.push_t) begin
            addr_raw = sp;
            we_raw   = 1'b1;
            push_acc = 1'b1;
          end else if (dec.pop_t) begin
            addr_raw = sp + 8'd1;
            pop_acc  = 1'b1;
          end else if (dec.is_rti) begin
            addr_raw   = sp + 8'd1;
            flags_raw  = 1'b1;
            stall_raw  = 1'b1;
            pop_acc    = 1'b1;
            next_state = RTI2;
          end else if (dec.use_alu) begin
            addr_raw = alu_addr;
            we_raw   = dec.mem_wr;
          end
        end else if (irq_take) begin
          // detect cycle: no memory access, pipeline frozen for PC capture
          stall_raw  = 1'b1;
          next_state = INT1;
        end
      end
      RTI2: begin
        addr_raw   = sp + 8'd1;
        pop_acc    = 1'b1;
        next_state = IDLE;
      end
      INT1: begin
        addr_raw   = sp;
        we_raw     = 1'b1;
        push_acc   = 1'b1;
        stall_raw  = 1'b1;
        next_state = INT2;
      end
      INT2: begin
        addr_raw   = sp;
        we_raw     = 1'b1;
        flags_raw  = 1'b1;
        push_acc   = 1'b1;
        ack_raw    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef STACK_GUARD_EN
  logic stk_err_q;

  // a faulting access is suppressed but the sequence still advances
  assign fault = (push_acc && (sp == STACK_LIMIT)) || (pop_acc && (sp == 8'hFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_err_q <= 1'b0;
    end else if (fault) begin
      stk_err_q <= 1'b1;
    end
  end

  assign stk_err = stk_err_q;
`else
  logic guard_unused;

  assign guard_unused = (sp == STACK_LIMIT);
  assign fault        = 1'b0;
  assign stk_err      = 1'b0;
`endif

  always_comb begin
    sp_next = sp;
    if (push_acc && !fault) begin
      sp_next = sp - 8'd1;
    end else if (pop_acc && !fault) begin
      sp_next = sp + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sp    <= SP_RESET;
    end else begin
      state <= next_state;
      sp    <= sp_next;
    end
  end

  // reset is asynchronous, so outputs are masked directly rather than via state
  assign mem_addr  = rst ? alu_addr : addr_raw;
  assign mem_we    = !rst && we_raw && !fault;
  assign flags_sel = !rst && flags_raw;
  assign stall     = !rst && stall_raw;
  assign irq_ack   = !rst && ack_raw;
  assign state_dbg = state;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl; expectations are hand-computed constants.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] ir;
  logic       valid;
  logic       irq_take;
  logic [7:0] alu_addr;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic       flags_sel;
  logic       stall;
  logic       irq_ack;
  logic [7:0] sp;
  logic       stk_err;
  state_t     state_dbg;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  stack_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .valid     (valid),
    .irq_take  (irq_take),
    .alu_addr  (alu_addr),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .flags_sel (flags_sel),
    .stall     (stall),
    .irq_ack   (irq_ack),
    .sp        (sp),
    .stk_err   (stk_err),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1ns after a rising edge; outputs are sampled 1ns later
  task automatic drive(input logic [7:0] i, input logic v, input logic irq, input logic [7:0] a);
    ir       = i;
    valid    = v;
    irq_take = irq;
    alu_addr = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h70, 1'b1, 1'b0, 8'h5A);
    tick();
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h5A);
    check("rst_stall", stall, 1'b0);
    check("rst_sp", sp, 8'hFF);
    check("rst_stk_err", stk_err, 1'b0);
    rst = 1'b0;

    // push then pop returns the same address
    drive(8'h70, 1'b1, 1'b0, 8'h00);
    check("push_addr", mem_addr, 8'hFF);
    check("push_we", mem_we, 1'b1);
    tick();
    check("push_sp", sp, 8'hFE);
    drive(8'h74, 1'b1, 1'b0, 8'h00);
    check("pop_addr", mem_addr, 8'hFF);
    check("pop_we", mem_we, 1'b0);
    tick();
    check("pop_sp", sp, 8'hFF);

    // RTI from sp=FD
    drive(8'h70, 1'b1, 1'b0, 8'h00);
    tick();
    tick();
    check("pre_rti_sp", sp, 8'hFD);
    drive(8'hBC, 1'b1, 1'b0, 8'h00);
    check("rti1_addr", mem_addr, 8'hFE);
    check("rti1_flags", flags_sel, 1'b1);
    check("rti1_stall", stall, 1'b1);
    check("rti1_we", mem_we, 1'b0);
    tick();
    drive(8'h70, 1'b1, 1'b1, 8'h00);
    check("rti2_state", state_dbg, RTI2);
    check("rti2_addr", mem_addr, 8'hFF);
    check("rti2_flags", flags_sel, 1'b0);
    check("rti2_stall", stall, 1'b0);
    check("rti2_we", mem_we, 1'b0);
    tick();
    check("rti_sp", sp, 8'hFF);
    check("rti_state", state_dbg, IDLE);

    // interrupt entry from sp=FF
    stall_cnt = 0;
    drive(8'h70, 1'b0, 1'b1, 8'h00);
    check("irq_det_we", mem_we, 1'b0);
    if (stall) stall_cnt++;
    tick();
    drive(8'hBC, 1'b1, 1'b1, 8'h00);
    check("int1_state", state_dbg, INT1);
    check("int1_addr", mem_addr, 8'hFF);
    check("int1_we", mem_we, 1'b1);
    check("int1_flags", flags_sel, 1'b0);
    check("int1_ack", irq_ack, 1'b0);
    if (stall) stall_cnt++;
    tick();
    check("int2_addr", mem_addr, 8'hFE);
    check("int2_we", mem_we, 1'b1);
    check("int2_flags", flags_sel, 1'b1);
    check("int2_ack", irq_ack, 1'b1);
    if (stall) stall_cnt++;
    tick();
    drive(8'h00, 1'b0, 1'b0, 8'h00);
    if (stall) stall_cnt++;
    check("int_stall_cycles", stall_cnt, 2);
    check("int_sp", sp, 8'hFD);
    check("int_ack_done", irq_ack, 1'b0);

    // irq waits while a valid STD executes
    drive(8'hC8, 1'b1, 1'b1, 8'h20);
    check("std_addr", mem_addr, 8'h20);
    check("std_we", mem_we, 1'b1);
    check("std_stall", stall, 1'b0);
    tick();
    check("std_no_int1", state_dbg, IDLE);
    check("std_sp", sp, 8'hFD);

    // other decode classes at sp=FD
    drive(8'hD0, 1'b1, 1'b0, 8'h33);
    check("ldi_addr", mem_addr, 8'h33);
    check("ldi_we", mem_we, 1'b0);
    drive(8'hE0, 1'b1, 1'b0, 8'h44);
    check("sti_we", mem_we, 1'b1);
    drive(8'h00, 1'b1, 1'b0, 8'h55);
    check("nop_addr", mem_addr, 8'h55);
    check("nop_we", mem_we, 1'b0);
    drive(8'h70, 1'b0, 1'b0, 8'h66);
    check("bubble_we", mem_we, 1'b0);
    drive(8'hB4, 1'b1, 1'b0, 8'h00);
    check("call_addr", mem_addr, 8'hFD);
    check("call_we", mem_we, 1'b1);
    tick();
    check("call_sp", sp, 8'hFC);
    drive(8'hB8, 1'b1, 1'b0, 8'h00);
    check("ret_addr", mem_addr, 8'hFD);
    tick();
    check("ret_sp", sp, 8'hFD);

    // pop at an empty stack
    do_reset();
    drive(8'h74, 1'b1, 1'b0, 8'h00);
    check("empty_pop_addr", mem_addr, 8'h00);
    tick();
`ifdef STACK_GUARD_EN
    check("empty_pop_sp", sp, 8'hFF);
    check("empty_pop_err", stk_err, 1'b1);
`else
    check("wrap_pop_sp", sp, 8'h00);
    drive(8'h70, 1'b1, 1'b0, 8'h00);
    check("wrap_push_addr", mem_addr, 8'h00);
    tick();
    check("wrap_push_sp", sp, 8'hFF);
    check("wrap_err", stk_err, 1'b0);
`endif

    // async reset in the middle of INT1
    do_reset();
    drive(8'h00, 1'b0, 1'b1, 8'h77);
    tick();
    drive(8'h00, 1'b0, 1'b0, 8'h77);
    check("mid_int1_state", state_dbg, INT1);
    rst = 1'b1;
    #1;
    check("rst_int1_state", state_dbg, IDLE);
    check("rst_int1_sp", sp, 8'hFF);
    check("rst_int1_we", mem_we, 1'b0);
    check("rst_int1_addr", mem_addr, 8'h77);
    check("rst_int1_err", stk_err, 1'b0);
    tick();
    rst = 1'b0;

`ifdef STACK_GUARD_EN
    // 129 pushes from FF: the 128th and 129th hit the limit
    for (int i = 0; i < 129; i++) begin
      drive(8'h70, 1'b1, 1'b0, 8'h00);
      if (i == 127) check("guard_we_blocked", mem_we, 1'b0);
      tick();
    end
    check("guard_sp", sp, 8'h80);
    check("guard_err", stk_err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
